// File: rtl/debug_hart_ctrl.sv
// -----------------------------------------------------------------------------
// debug_hart_ctrl
//
// Hart-side responder for the debug module's run-control and abstract-register
// interface. It sequences halt / resume / hart-reset requests, stalls and
// redirects the RV32 core, owns dcsr, dpc, dscratch0 and misa, and forwards
// GPR abstract accesses to the core register file.
//
// Ports
//   CLK, RST          clock, asynchronous active-high reset
//   I_HALTREQ         halt request (level)
//   I_RESUMEREQ       resume request (level)
//   I_HARTRESET       hart reset request (level)
//   O_HALTED          hart is halted
//   O_RUNNING         hart is running
//   O_RESUMEACK       resume acknowledged (high while resuming)
//   I_AR_EN/WR/AD/DO  abstract register access strobe, direction, regno, wdata
//   O_AR_DI           registered abstract read data
//   O_CORE_STALL      stall pipeline at next instruction boundary
//   I_CORE_IDLE       core stopped at an instruction boundary
//   I_CORE_PC         PC of the next instruction to execute
//   O_CORE_PC_LOAD    one-cycle pulse: core loads O_CORE_PC
//   O_CORE_PC         resume PC (dpc)
//   O_CORE_RESET      core reset
//   O_GPR_WE/ADDR/WDATA  GPR write port / read index
//   I_GPR_RDATA       combinational GPR read data for O_GPR_ADDR
// -----------------------------------------------------------------------------
module debug_hart_ctrl #(
    parameter logic [31:0] MISA_VAL       = 32'h4000_1105,
    parameter logic [3:0]  DCSR_XDEBUGVER = 4'd4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        I_HALTREQ,
    input  logic        I_RESUMEREQ,
    input  logic        I_HARTRESET,
    output logic        O_HALTED,
    output logic        O_RUNNING,
    output logic        O_RESUMEACK,
    input  logic        I_AR_EN,
    input  logic        I_AR_WR,
    input  logic [15:0] I_AR_AD,
    input  logic [31:0] I_AR_DO,
    output logic [31:0] O_AR_DI,
    output logic        O_CORE_STALL,
    input  logic        I_CORE_IDLE,
    input  logic [31:0] I_CORE_PC,
    output logic        O_CORE_PC_LOAD,
    output logic [31:0] O_CORE_PC,
    output logic        O_CORE_RESET,
    output logic        O_GPR_WE,
    output logic [4:0]  O_GPR_ADDR,
    output logic [31:0] O_GPR_WDATA,
    input  logic [31:0] I_GPR_RDATA
);

    typedef enum logic [2:0] {
        ST_RUN,
        ST_HALTING,
        ST_HALTED,
        ST_RESUMING,
        ST_HRESET
    } state_e;

    localparam logic [15:0] REG_DCSR      = 16'h07B0;
    localparam logic [15:0] REG_DPC       = 16'h07B1;
    localparam logic [15:0] REG_DSCRATCH0 = 16'h07B2;
    localparam logic [15:0] REG_MISA      = 16'h0301;

    state_e      state_q, state_d;
    logic        pc_load_q, pc_load_d;
    logic [31:0] dpc_q, dpc_d;
    logic [31:0] dscratch0_q, dscratch0_d;
    logic [31:0] ar_di_q, ar_di_d;
    // dcsr is kept as its individual live fields; the constant parts are
    // only assembled on read.
    logic        ebreakm_q, ebreakm_d;
    logic        step_q, step_d;
    logic [1:0]  prv_q, prv_d;
    logic [2:0]  cause_q, cause_d;

    logic        halted;
    logic        is_gpr;
    logic        gpr_x0;
    logic        ar_write;
    logic [31:0] dcsr_rd;
    logic [31:0] rd_val;

    assign halted   = (state_q == ST_HALTED);
    assign is_gpr   = (I_AR_AD[15:5] == 11'h080);   // 0x1000..0x101F
    assign gpr_x0   = (I_AR_AD[4:0] == 5'd0);
    // Accesses sample the current state, so one landing on the same edge
    // as HALTED->RESUMING is still honoured.
    assign ar_write = I_AR_EN & I_AR_WR & halted;
    assign dcsr_rd  = {DCSR_XDEBUGVER, 12'd0, ebreakm_q, 6'd0, cause_q,
                       3'd0, step_q, prv_q};

    // ---------------------------------------------------------------- FSM
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        pc_load_d = 1'b0;
        if (I_HARTRESET) begin
            state_d = ST_HRESET;
        end else begin
            unique case (state_q)
                ST_RUN:      if (I_HALTREQ) state_d = ST_HALTING;
                ST_HALTING:  if (I_CORE_IDLE) state_d = ST_HALTED;
                ST_HALTED:   if (I_RESUMEREQ && !I_HALTREQ) begin
                                 state_d   = ST_RESUMING;
                                 pc_load_d = 1'b1;
                             end
                ST_RESUMING: if (I_HALTREQ) state_d = ST_HALTING;
                             else if (!I_RESUMEREQ) state_d = ST_RUN;
                ST_HRESET:   state_d = I_HALTREQ ? ST_HALTING : ST_RUN;
                default:     state_d = ST_RUN;
            endcase
        end
    end

    // ------------------------------------------------------ register file
    always_comb begin
        rd_val = 32'd0;
        if (is_gpr) begin
            rd_val = gpr_x0 ? 32'd0 : I_GPR_RDATA;
        end else begin
            unique case (I_AR_AD)
                REG_DCSR:      rd_val = dcsr_rd;
                REG_DPC:       rd_val = dpc_q;
                REG_DSCRATCH0: rd_val = dscratch0_q;
                REG_MISA:      rd_val = MISA_VAL;
                default:       rd_val = 32'd0;
            endcase
        end
    end

    always_comb begin
        ar_di_d     = ar_di_q;
        dpc_d       = dpc_q;
        dscratch0_d = dscratch0_q;
        ebreakm_d   = ebreakm_q;
        step_d      = step_q;
        prv_d       = prv_q;
        cause_d     = cause_q;

        // Read data holds until the next access; outside HALTED it reads 0.
        if (I_AR_EN) begin
            ar_di_d = halted ? rd_val : 32'd0;
        end

        if (ar_write && !is_gpr) begin
            unique case (I_AR_AD)
                REG_DCSR: begin
                    ebreakm_d = I_AR_DO[15];
                    step_d    = I_AR_DO[2];
                    prv_d     = I_AR_DO[1:0];
                end
                REG_DPC:       dpc_d       = {I_AR_DO[31:1], 1'b0};
                REG_DSCRATCH0: dscratch0_d = I_AR_DO;
                default:       ;
            endcase
        end

        if (state_q == ST_HALTING && state_d == ST_HALTED) begin
            dpc_d   = I_CORE_PC;
            cause_d = 3'd3;          // cause = haltreq
        end

        // Hart reset wins over any concurrent write.
        if (I_HARTRESET) begin
            dpc_d     = 32'd0;
            ebreakm_d = 1'b0;
            step_d    = 1'b0;
            prv_d     = 2'b11;
            cause_d   = 3'd0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_RUN;
            pc_load_q   <= 1'b0;
            dpc_q       <= 32'd0;
            dscratch0_q <= 32'd0;
            ar_di_q     <= 32'd0;
            ebreakm_q   <= 1'b0;
            step_q      <= 1'b0;
            prv_q       <= 2'b11;
            cause_q     <= 3'd0;
        end else begin
            state_q     <= state_d;
            pc_load_q   <= pc_load_d;
            dpc_q       <= dpc_d;
            dscratch0_q <= dscratch0_d;
            ar_di_q     <= ar_di_d;
            ebreakm_q   <= ebreakm_d;
            step_q      <= step_d;
            prv_q       <= prv_d;
            cause_q     <= cause_d;
        end
    end

    // ------------------------------------------------------------ outputs
    assign O_RUNNING      = (state_q == ST_RUN);
    assign O_HALTED       = halted;
    assign O_RESUMEACK    = (state_q == ST_RESUMING);
    assign O_CORE_STALL   = (state_q == ST_HALTING) || halted ||
                            (state_q == ST_RESUMING);
    assign O_CORE_RESET   = (state_q == ST_HRESET);
    assign O_CORE_PC_LOAD = pc_load_q;
    assign O_CORE_PC      = dpc_q;
    assign O_AR_DI        = ar_di_q;

    assign O_GPR_ADDR  = I_AR_EN ? I_AR_AD[4:0] : 5'd0;
    assign O_GPR_WE    = ar_write & is_gpr & ~gpr_x0;
    assign O_GPR_WDATA = I_AR_DO;

endmodule

// File: doc/debug_hart_ctrl.md
Name: debug_hart_ctrl

Overview:
Hart-side responder for the debug module's run-control and abstract-register interface. It accepts halt, resume and hart-reset requests and reports halted, running and resume-ack status. It stalls and redirects the core, owns dcsr, dpc, dscratch0 and misa, and forwards GPR abstract accesses to the core register file. It sits between the debug core and the RV32 pipeline, and is the hart-side counterpart of the debug module's halt/resume/AR signals.

Parameters:
MISA_VAL, 32'h4000_1105, read-only misa value (RV32IMAC).
DCSR_XDEBUGVER, 4'd4, dcsr[31:28] constant.

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous, active-high reset
I_HALTREQ  in  1  halt request, level
I_RESUMEREQ  in  1  resume request, level
I_HARTRESET  in  1  hart reset request, level
O_HALTED  out  1  hart halted
O_RUNNING  out  1  hart running
O_RESUMEACK  out  1  resume acknowledged
I_AR_EN  in  1  abstract register access strobe, one cycle
I_AR_WR  in  1  1=write, 0=read
I_AR_AD  in  16  abstract regno
I_AR_DO  in  32  write data from debug module
O_AR_DI  out  32  read data to debug module
O_CORE_STALL  out  1  stall the pipeline at the next instruction boundary
I_CORE_IDLE  in  1  core has stopped at an instruction boundary
I_CORE_PC  in  32  PC of the next instruction to execute
O_CORE_PC_LOAD  out  1  one-cycle pulse: core loads O_CORE_PC
O_CORE_PC  out  32  resume PC, equal to dpc
O_CORE_RESET  out  1  core reset
O_GPR_WE  out  1  GPR write strobe
O_GPR_ADDR  out  5  GPR index
O_GPR_WDATA  out  32  GPR write data
I_GPR_RDATA  in  32  combinational GPR read data for O_GPR_ADDR

Behaviour:
States: RUN, HALTING, HALTED, RESUMING, HRESET. State resets to RUN.
Outputs decoded from state:
- O_RUNNING = RUN.
- O_HALTED = HALTED.
- O_RESUMEACK = RESUMING.
- O_CORE_STALL = HALTING or HALTED or RESUMING.
- O_CORE_RESET = HRESET.
Under RST the outputs are therefore RUNNING=1 and everything else 0. dpc, dscratch0 and O_AR_DI reset to 0. dcsr resets to {xdebugver, 0..., prv=2'b11}.

Transitions, evaluated per clock; priority is I_HARTRESET, then I_HALTREQ, then I_RESUMEREQ:
- Any state with I_HARTRESET=1 -> HRESET. dcsr returns to its reset value; dpc is cleared.
- HRESET with I_HARTRESET=0 -> HALTING if I_HALTREQ=1 (halt-on-reset), else RUN.
- RUN with I_HALTREQ=1 -> HALTING.
- HALTING with I_CORE_IDLE=1 -> HALTED. Same edge: dpc <= I_CORE_PC, dcsr.cause[8:6] <= 3'd3.
- HALTED with I_RESUMEREQ=1 and I_HALTREQ=0 -> RESUMING. O_CORE_PC_LOAD pulses on the first RESUMING cycle only, with O_CORE_PC = dpc.
- RESUMING holds until I_RESUMEREQ=0, then -> RUN. I_HALTREQ during RESUMING -> HALTING.
- I_HALTREQ held while already HALTED: no effect.
- I_RESUMEREQ while in RUN: ignored.

Abstract access:
- Honoured only when state==HALTED. Otherwise a read returns 0 and a write is dropped.
- Read data is registered: O_AR_DI is valid on the cycle after I_AR_EN and holds until the next access.
- Regno map:
  - 0x1000-0x101F: GPR x0..x31. O_GPR_ADDR = I_AR_AD[4:0], driven combinationally during I_AR_EN. O_GPR_WE = I_AR_EN & I_AR_WR & halted & (addr!=0). Reading x0 returns 0.
  - 0x07B0 dcsr: writable bits are ebreakm[15], step[2], prv[1:0]. xdebugver and cause are read-only; all other bits read 0.
  - 0x07B1 dpc: write stores I_AR_DO with bit0 forced to 0.
  - 0x07B2 dscratch0: full 32-bit read/write.
  - 0x0301 misa: reads MISA_VAL; writes are ignored.
  - Any other regno: reads 0; writes are ignored.
- An access on the same cycle as a halted->RESUMING transition is still honoured, because state is sampled before update.
- A dpc write followed by resume: O_CORE_PC equals the written value.
- RST mid-operation forces RUN immediately and clears all pending pulses.

Test Plan:
- Reset release with all inputs 0 -> O_RUNNING=1, O_HALTED=0, O_RESUMEACK=0, O_CORE_STALL=0, O_AR_DI=0.
- HALTREQ=1 in RUN, I_CORE_IDLE raised 3 cycles later with I_CORE_PC=0x8000_0040 -> STALL=1 immediately; HALTED=1 the cycle after IDLE; a read of 0x07B1 returns 0x8000_0040; a read of 0x07B0 returns cause=3 and [31:28]=4.
- Halted: write 0x1005=0xDEAD_BEEF -> GPR_WE=1, ADDR=5, WDATA=0xDEAD_BEEF. Write 0x1000 -> GPR_WE stays 0. Read 0x0301 -> 0x4000_1105. Read 0x0123 -> 0.
- Halted: write dpc=0x8000_0101, then RESUMEREQ=1 for 4 cycles -> one PC_LOAD pulse with O_CORE_PC=0x8000_0100; RESUMEACK=1 until RESUMEREQ falls; then RUNNING=1 and STALL=0.
- Running: write 0x07B2=0x1234 -> dropped; a read returns 0 and GPR_WE is never asserted.
- HARTRESET=1 while HALTED with HALTREQ=1, then HARTRESET released -> O_CORE_RESET=1 during the request; on release the block enters HALTING, then HALTED after IDLE; dcsr.step is cleared.
